// File: rtl/core_scheduler.sv
// Job sequencer for a bank of face-detection cores: dispatches tiles to idle
// cores, counts completions and round-robin arbitrates the shared result port.
module core_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int TILE_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          size,
    input  logic [TILE_W-1:0]    num_tiles,
    output logic [31:0]          unit_size,
    output logic [NUM_CORES-1:0] core_start,
    output logic [TILE_W-1:0]    core_tile,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] res_req,
    output logic [NUM_CORES-1:0] res_grant,
    output logic                 busy,
    output logic                 all_done,
    output logic [TILE_W-1:0]    tiles_done,
    output logic                 err
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DISPATCH,
        DRAIN,
        FINISH
    } state_t;

    state_t               state;
    logic [31:0]          size_q;
    logic [TILE_W-1:0]    num_tiles_q;
    logic [TILE_W-1:0]    next_tile;
    logic [NUM_CORES-1:0] core_busy;
    logic [PTR_W-1:0]     rr_ptr;

    logic [NUM_CORES-1:0] idle_pick;
    logic                 idle_found;
    logic                 dispatch;
    logic [NUM_CORES-1:0] accepted_done;
    logic [NUM_CORES-1:0] stray_done;
    logic [TILE_W-1:0]    done_count;

    logic [NUM_CORES-1:0] hi_req;
    logic [NUM_CORES-1:0] pick_src;
    logic [NUM_CORES-1:0] grant_pick;
    logic [PTR_W-1:0]     grant_next_ptr;
    logic                 grant_found;

    // Busy bits are registered, so a core freed by core_done this cycle only
    // becomes a dispatch candidate in the following cycle.
    always_comb begin
        idle_pick  = '0;
        idle_found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!core_busy[i] && !idle_found) begin
                idle_pick[i] = 1'b1;
                idle_found   = 1'b1;
            end
        end
    end

    assign dispatch   = (state == DISPATCH) && idle_found;
    assign core_start = dispatch ? idle_pick : '0;
    assign core_tile  = dispatch ? next_tile : '0;
    assign busy       = (state != IDLE);
    assign all_done   = (state == FINISH);

    assign accepted_done = core_done & core_busy;
    assign stray_done    = core_done & ~core_busy;

    always_comb begin
        done_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accepted_done[i]) begin
                done_count = done_count + TILE_W'(1);
            end
        end
    end

    // Round-robin: requests at or above the pointer win first, otherwise wrap
    // around to the lowest requesting index.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hi_req[i] = res_req[i] && (PTR_W'(i) >= rr_ptr);
        end
        pick_src       = (hi_req != '0) ? hi_req : res_req;
        grant_pick     = '0;
        grant_next_ptr = '0;
        grant_found    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_src[i] && !grant_found) begin
                grant_pick[i]  = 1'b1;
                grant_next_ptr = (i == NUM_CORES - 1) ? '0 : PTR_W'(i + 1);
                grant_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            size_q      <= '0;
            num_tiles_q <= '0;
            next_tile   <= '0;
            core_busy   <= '0;
            unit_size   <= '0;
            tiles_done  <= '0;
            err         <= 1'b0;
        end else begin
            core_busy  <= (core_busy & ~core_done) | core_start;
            tiles_done <= tiles_done + done_count;
            if (stray_done != '0) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        size_q      <= size;
                        num_tiles_q <= num_tiles;
                        tiles_done  <= '0;
                        next_tile   <= '0;
                        err         <= (stray_done != '0);
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    unit_size <= size_q >> 3;
                    state     <= (num_tiles_q != '0) ? DISPATCH : FINISH;
                end
                DISPATCH: begin
                    if (dispatch) begin
                        next_tile <= next_tile + TILE_W'(1);
                        if (next_tile == num_tiles_q - TILE_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (core_busy == '0 && res_req == '0 && res_grant == '0) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A dropped request releases the grant on that edge; the next winner is
    // chosen only once the port has been seen free for a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_grant <= '0;
            rr_ptr    <= '0;
        end else if (res_grant != '0) begin
            if ((res_grant & res_req) == '0) begin
                res_grant <= '0;
            end
        end else if (grant_found) begin
            res_grant <= grant_pick;
            rr_ptr    <= grant_next_ptr;
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: directed jobs push expected dispatches,
// completions and grants; a negedge monitor pops and compares them.
module tb_core_scheduler;

    localparam int NUM_CORES = 4;
    localparam int TILE_W    = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [31:0]          size;
    logic [TILE_W-1:0]    num_tiles;
    logic [31:0]          unit_size;
    logic [NUM_CORES-1:0] core_start;
    logic [TILE_W-1:0]    core_tile;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] res_req;
    logic [NUM_CORES-1:0] res_grant;
    logic                 busy;
    logic                 all_done;
    logic [TILE_W-1:0]    tiles_done;
    logic                 err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [NUM_CORES-1:0] start;
        logic [TILE_W-1:0]    tile;
        int                   cycle;
    } disp_t;

    typedef struct {
        logic [TILE_W-1:0] tiles;
        int                cycle;
    } done_t;

    typedef struct {
        logic [NUM_CORES-1:0] grant;
        int                   len;
    } grant_t;

    disp_t  disp_q[$];
    done_t  done_q[$];
    grant_t grant_q[$];

    core_scheduler #(
        .NUM_CORES(NUM_CORES),
        .TILE_W   (TILE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .size      (size),
        .num_tiles (num_tiles),
        .unit_size (unit_size),
        .core_start(core_start),
        .core_tile (core_tile),
        .core_done (core_done),
        .res_req   (res_req),
        .res_grant (res_grant),
        .busy      (busy),
        .all_done  (all_done),
        .tiles_done(tiles_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [31:0] sz, input logic [TILE_W-1:0] nt,
                                 input logic [NUM_CORES-1:0] done);
        start     = st;
        size      = sz;
        num_tiles = nt;
        core_done = done;
        tick();
        start     = 1'b0;
        core_done = '0;
    endtask

    task automatic waitGrant(input logic [NUM_CORES-1:0] expected);
        int n = 0;
        while (res_grant == '0 && n < 20) begin
            tick();
            n++;
        end
        if (res_grant == '0) begin
            checkOutput("grant_wait", 32'(res_grant), 32'(expected));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_unit_size"},  unit_size,          32'd0);
        checkOutput({tag, "_core_start"}, 32'(core_start),    32'd0);
        checkOutput({tag, "_core_tile"},  32'(core_tile),     32'd0);
        checkOutput({tag, "_res_grant"},  32'(res_grant),     32'd0);
        checkOutput({tag, "_busy"},       32'(busy),          32'd0);
        checkOutput({tag, "_all_done"},   32'(all_done),      32'd0);
        checkOutput({tag, "_tiles_done"}, 32'(tiles_done),    32'd0);
        checkOutput({tag, "_err"},        32'(err),           32'd0);
    endtask

    disp_t                de;
    done_t                dd;
    grant_t               ge;
    logic [NUM_CORES-1:0] cur_grant = '0;
    int                   grant_len = 0;

    // Monitor: every dispatch, completion and grant the DUT presents must match
    // the next expectation queued by the stimulus.
    always @(negedge clk) begin
        if (!reset) begin
            if (core_start != '0) begin
                if (disp_q.size() == 0) begin
                    checkOutput("unexpected_dispatch", 32'(core_start), 32'd0);
                end else begin
                    de = disp_q.pop_front();
                    checkOutput("dispatch_core",  32'(core_start), 32'(de.start));
                    checkOutput("dispatch_tile",  32'(core_tile),  32'(de.tile));
                    checkOutput("dispatch_cycle", 32'(cyc),        32'(de.cycle));
                end
            end
            if (all_done) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_all_done", 32'(all_done), 32'd0);
                end else begin
                    dd = done_q.pop_front();
                    checkOutput("all_done_tiles", 32'(tiles_done), 32'(dd.tiles));
                    checkOutput("all_done_cycle", 32'(cyc),        32'(dd.cycle));
                end
            end
            if (res_grant !== cur_grant) begin
                if (cur_grant != '0) begin
                    if (grant_q.size() == 0) begin
                        checkOutput("unexpected_grant", 32'(cur_grant), 32'd0);
                    end else begin
                        ge = grant_q.pop_front();
                        checkOutput("grant_value", 32'(cur_grant), 32'(ge.grant));
                        checkOutput("grant_len",   32'(grant_len), 32'(ge.len));
                    end
                end
                cur_grant = res_grant;
                grant_len = (res_grant != '0) ? 1 : 0;
            end else if (res_grant != '0) begin
                grant_len++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        size      = '0;
        num_tiles = '0;
        core_done = '0;
        res_req   = '0;
        repeat (3) tick();
        checkResetOutputs("reset");

        // Four tiles on four cores, first start right after reset release
        reset = 1'b0;
        disp_q.push_back('{4'b0001, 8'd0, cyc + 2});
        disp_q.push_back('{4'b0010, 8'd1, cyc + 3});
        disp_q.push_back('{4'b0100, 8'd2, cyc + 4});
        disp_q.push_back('{4'b1000, 8'd3, cyc + 5});
        applyStimulus(1'b1, 32'd64, 8'd4, '0);
        checkOutput("setup_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("unit_size_64", unit_size, 32'd8);
        repeat (4) tick();
        done_q.push_back('{8'd4, cyc + 4});
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0011);
        checkOutput("tiles_done_two", 32'(tiles_done), 32'd2);
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0100);
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b1000);
        repeat (2) tick();
        checkOutput("job4_idle_busy", 32'(busy), 32'd0);
        checkOutput("job4_tiles_done", 32'(tiles_done), 32'd4);

        // Six tiles: freed cores get the next tile one cycle after their done
        disp_q.push_back('{4'b0001, 8'd0, cyc + 2});
        disp_q.push_back('{4'b0010, 8'd1, cyc + 3});
        disp_q.push_back('{4'b0100, 8'd2, cyc + 4});
        disp_q.push_back('{4'b1000, 8'd3, cyc + 5});
        applyStimulus(1'b1, 32'd100, 8'd6, '0);
        tick();
        checkOutput("unit_size_100", unit_size, 32'd12);
        repeat (5) tick();
        disp_q.push_back('{4'b0100, 8'd4, cyc + 1});
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0100);
        tick();
        disp_q.push_back('{4'b0001, 8'd5, cyc + 1});
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0001);
        tick();
        checkOutput("drain_busy", 32'(busy), 32'd1);
        done_q.push_back('{8'd6, cyc + 2});
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b1111);
        checkOutput("tiles_done_six", 32'(tiles_done), 32'd6);
        repeat (3) tick();
        checkOutput("job6_idle_busy", 32'(busy), 32'd0);

        // Stray completion on an idle core
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0010);
        checkOutput("stray_err", 32'(err), 32'd1);
        checkOutput("stray_tiles_done", 32'(tiles_done), 32'd6);
        repeat (3) tick();
        checkOutput("stray_err_sticky", 32'(err), 32'd1);

        // Empty job clears err and finishes two cycles after start
        done_q.push_back('{8'd0, cyc + 2});
        applyStimulus(1'b1, 32'd64, 8'd0, '0);
        checkOutput("empty_setup_busy", 32'(busy), 32'd1);
        checkOutput("empty_err_cleared", 32'(err), 32'd0);
        checkOutput("empty_tiles_cleared", 32'(tiles_done), 32'd0);
        tick();
        checkOutput("empty_finish_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("empty_idle_busy", 32'(busy), 32'd0);

        // All four request the result port; each holds its grant three cycles
        grant_q.push_back('{4'b0001, 3});
        grant_q.push_back('{4'b0010, 3});
        grant_q.push_back('{4'b0100, 3});
        grant_q.push_back('{4'b1000, 3});
        res_req = 4'b1111;
        for (int i = 0; i < NUM_CORES; i++) begin
            waitGrant(4'(1 << i));
            tick();
            tick();
            res_req[i] = 1'b0;
            tick();
        end
        repeat (2) tick();

        grant_q.push_back('{4'b0100, 1});
        res_req = 4'b0100;
        waitGrant(4'b0100);
        res_req = '0;
        repeat (2) tick();

        // Reset in the middle of dispatch with cores 0 and 1 busy
        disp_q.push_back('{4'b0001, 8'd0, cyc + 2});
        disp_q.push_back('{4'b0010, 8'd1, cyc + 3});
        applyStimulus(1'b1, 32'd64, 8'd8, '0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        checkResetOutputs("midjob_reset");
        tick();
        tick();
        reset = 1'b0;
        disp_q.push_back('{4'b0001, 8'd0, cyc + 2});
        disp_q.push_back('{4'b0010, 8'd1, cyc + 3});
        applyStimulus(1'b1, 32'd64, 8'd2, '0);
        tick();
        checkOutput("restart_unit_size", unit_size, 32'd8);
        repeat (2) tick();
        done_q.push_back('{8'd2, cyc + 2});
        applyStimulus(1'b0, 32'd0, 8'd0, 4'b0011);
        repeat (2) tick();
        checkOutput("restart_idle_busy", 32'(busy), 32'd0);

        // Pointer was at core 3 before reset; after reset core 1 must win
        grant_q.push_back('{4'b0010, 1});
        res_req = 4'b1010;
        waitGrant(4'b0010);
        res_req = '0;
        repeat (3) tick();

        checkOutput("disp_q_empty",  32'(disp_q.size()),  32'd0);
        checkOutput("done_q_empty",  32'(done_q.size()),  32'd0);
        checkOutput("grant_q_empty", 32'(grant_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
